// File: rtl/bp_fe_queue_rollback.sv
// bp_fe_queue_rollback: checkpointed circular buffer between pc_gen and the backend.
// Entries are read (rptr) speculatively and only retired on commit (cptr); the
// backend may rewind rptr to cptr (roll) or flush everything (clr).
module bp_fe_queue_rollback #(
   parameter int data_width_p = 64,
   parameter int els_p        = 8
) (
   input  logic                      clk_i,
   input  logic                      reset_i,

   input  logic [data_width_p-1:0]   fe_queue_i,
   input  logic                      fe_queue_v_i,
   output logic                      fe_queue_ready_o,

   output logic [data_width_p-1:0]   fe_queue_o,
   output logic                      fe_queue_v_o,
   input  logic                      fe_queue_yumi_i,

   input  logic                      deq_v_i,
   input  logic                      roll_v_i,
   input  logic                      clr_v_i,

   output logic [$clog2(els_p):0]    count_o
);

   localparam int idx_width_lp = $clog2(els_p);
   localparam int ptr_width_lp = idx_width_lp + 1;

   // Storage is never reset; only the pointers define which entries are live.
   logic [data_width_p-1:0] mem_q [els_p];

   logic [ptr_width_lp-1:0] wptr_q, wptr_d;
   logic [ptr_width_lp-1:0] rptr_q, rptr_d;
   logic [ptr_width_lp-1:0] cptr_q, cptr_d;
   logic [ptr_width_lp-1:0] cptr_commit;
   logic [ptr_width_lp-1:0] occupancy;

   logic full;
   logic empty_rd;
   logic enq_fire;
   logic rd_fire;
   logic deq_ok;

   // The wrap bit distinguishes full (difference == els_p) from empty (difference == 0).
   assign occupancy = wptr_q - cptr_q;
   assign full      = (occupancy == ptr_width_lp'(els_p));
   assign empty_rd  = (rptr_q == wptr_q);

   // Handshake outputs depend only on registered state plus the flush/rewind controls,
   // so a commit or enqueue this cycle never shows up before the next edge.
   assign fe_queue_ready_o = ~reset_i & ~full & ~clr_v_i;
   assign fe_queue_v_o     = ~reset_i & ~empty_rd & ~clr_v_i & ~roll_v_i;
   assign fe_queue_o       = mem_q[rptr_q[idx_width_lp-1:0]];
   assign count_o          = reset_i ? '0 : occupancy;

   assign enq_fire = fe_queue_v_i & fe_queue_ready_o;
   assign rd_fire  = fe_queue_yumi_i & fe_queue_v_o;
   // A commit past the read pointer would retire an unread entry, so it is dropped.
   assign deq_ok   = deq_v_i & (cptr_q != rptr_q);

   assign cptr_commit = cptr_q + ptr_width_lp'(deq_ok);

   // Next-state pointers: clr beats roll, roll lands on the post-commit cptr, then reads.
   always_comb begin
      wptr_d = wptr_q + ptr_width_lp'(enq_fire);
      cptr_d = cptr_commit;
      rptr_d = rptr_q + ptr_width_lp'(rd_fire);
      if (roll_v_i) begin
         rptr_d = cptr_commit;
      end
      if (clr_v_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cptr_d = '0;
      end
   end

   // Pointer registers with asynchronous reset that discards every entry at once.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cptr_q <= cptr_d;
      end
   end

   // Entry write on a successful enqueue handshake.
   always_ff @(posedge clk_i) begin
      if (enq_fire) begin
         mem_q[wptr_q[idx_width_lp-1:0]] <= fe_queue_i;
      end
   end

   // A commit must only retire entries the backend has already read.
   property p_deq_legal;
      @(posedge clk_i) disable iff (reset_i)
         (deq_v_i & ~clr_v_i) |-> (cptr_q != rptr_q);
   endproperty
   a_deq_legal: assert property (p_deq_legal);

endmodule

// File: tb/tb_bp_fe_queue_rollback.sv
// Self-checking bench for bp_fe_queue_rollback (els_p=4, data_width_p=8).
module tb_bp_fe_queue_rollback;

   logic       clk_i;
   logic       reset_i;
   logic [7:0] fe_queue_i;
   logic       fe_queue_v_i;
   logic       fe_queue_ready_o;
   logic [7:0] fe_queue_o;
   logic       fe_queue_v_o;
   logic       fe_queue_yumi_i;
   logic       deq_v_i;
   logic       roll_v_i;
   logic       clr_v_i;
   logic [2:0] count_o;

   int errors = 0;
   int checks = 0;

   bp_fe_queue_rollback #(.data_width_p(8), .els_p(4)) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .fe_queue_i       (fe_queue_i),
      .fe_queue_v_i     (fe_queue_v_i),
      .fe_queue_ready_o (fe_queue_ready_o),
      .fe_queue_o       (fe_queue_o),
      .fe_queue_v_o     (fe_queue_v_o),
      .fe_queue_yumi_i  (fe_queue_yumi_i),
      .deq_v_i          (deq_v_i),
      .roll_v_i         (roll_v_i),
      .clr_v_i          (clr_v_i),
      .count_o          (count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       enq;
      logic [7:0] din;
      logic       yumi;
      logic       deq;
      logic       roll;
      logic       clr;
      logic       e_ready;
      logic       e_v;
      logic [7:0] e_data;
      logic [2:0] e_count;
      logic       chk_data;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      fe_queue_v_i    = 1'b0;
      fe_queue_i      = 8'h00;
      fe_queue_yumi_i = 1'b0;
      deq_v_i         = 1'b0;
      roll_v_i        = 1'b0;
      clr_v_i         = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [7:0] sb[$];
      logic [7:0] exp_d;
      int sent, wr, rd, cm, cyc;

      // enq din yumi deq roll clr | ready v data count chk_data
      vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
      vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b1};
      vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b1};
      vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b1};
      vecs[4]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1};
      vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1};
      vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 3'd4, 1'b1};
      vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 3'd4, 1'b1};
      vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 3'd3, 1'b1};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 3'd3, 1'b1};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1};
      vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1};
      vecs[13] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0};
      vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 3'd3, 1'b1};
      vecs[15] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0};
      vecs[16] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
      vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 3'd1, 1'b1};

      idle_inputs();
      reset_i = 1'b1;
      #2;
      check("rst_ready", fe_queue_ready_o, 1'b0);
      check("rst_v",     fe_queue_v_o,     1'b0);
      check("rst_count", count_o,          3'd0);
      tick();
      tick();
      reset_i = 1'b0;

      // Table phase: fill, drain, commit, roll, roll+commit+enqueue, clear.
      for (int i = 0; i < 18; i++) begin
         fe_queue_v_i    = vecs[i].enq;
         fe_queue_i      = vecs[i].din;
         fe_queue_yumi_i = vecs[i].yumi;
         deq_v_i         = vecs[i].deq;
         roll_v_i        = vecs[i].roll;
         clr_v_i         = vecs[i].clr;
         #1;
         check($sformatf("vec%0d_ready", i), fe_queue_ready_o, vecs[i].e_ready);
         check($sformatf("vec%0d_v", i),     fe_queue_v_o,     vecs[i].e_v);
         check($sformatf("vec%0d_count", i), count_o,          vecs[i].e_count);
         if (vecs[i].chk_data) begin
            check($sformatf("vec%0d_data", i), fe_queue_o, vecs[i].e_data);
         end
         $display("vec %0d: ready=%0b v=%0b data=%02h count=%0d",
                  i, fe_queue_ready_o, fe_queue_v_o, fe_queue_o, count_o);
         tick();
      end

      // Flush before streaming so all pointers start at zero.
      idle_inputs();
      clr_v_i = 1'b1;
      #1;
      check("clr_v", fe_queue_v_o, 1'b0);
      tick();
      clr_v_i = 1'b0;
      #1;
      check("clr_count", count_o, 3'd0);

      // Streaming phase with a scoreboard; pointers wrap several times.
      sent = 0; wr = 0; rd = 0; cm = 0; cyc = 0;
      while ((sent < 20 || sb.size() > 0 || cm < rd) && cyc < 200) begin
         fe_queue_yumi_i = (sb.size() > 0);
         deq_v_i         = (cm < rd);
         fe_queue_v_i    = (sent < 20) && ((wr - cm - (deq_v_i ? 1 : 0)) == 0);
         fe_queue_i      = sent[7:0];
         #1;
         check("strm_count", count_o, wr - cm);
         check("strm_count_le1", (count_o <= 3'd1), 1'b1);
         check("strm_v", fe_queue_v_o, (sb.size() > 0));
         if (fe_queue_yumi_i) begin
            exp_d = sb.pop_front();
            check("strm_data", fe_queue_o, exp_d);
            $display("stream read: data=%02h expected=%02h count=%0d", fe_queue_o, exp_d, count_o);
            rd++;
         end
         if (fe_queue_v_i) begin
            check("strm_ready", fe_queue_ready_o, 1'b1);
            sb.push_back(sent[7:0]);
            sent++;
            wr++;
         end
         if (deq_v_i) cm++;
         tick();
         cyc++;
      end
      if (cyc >= 200) begin
         checks++;
         errors++;
         $display("FAIL strm_timeout: got %0d cycles required under 200", cyc);
      end
      check("strm_sent", sent, 20);

      // Async reset with entries resident: outputs drop with no clock edge.
      idle_inputs();
      fe_queue_v_i = 1'b1;
      fe_queue_i   = 8'hA1;
      tick();
      fe_queue_i   = 8'hA2;
      tick();
      idle_inputs();
      #1;
      check("pre_rst_count", count_o, 3'd2);
      check("pre_rst_v", fe_queue_v_o, 1'b1);
      #1;
      reset_i = 1'b1;
      #1;
      check("async_rst_v",     fe_queue_v_o,     1'b0);
      check("async_rst_ready", fe_queue_ready_o, 1'b0);
      check("async_rst_count", count_o,          3'd0);
      $display("async reset: ready=%0b v=%0b count=%0d", fe_queue_ready_o, fe_queue_v_o, count_o);
      tick();
      reset_i = 1'b0;
      #1;
      check("post_rst_v",     fe_queue_v_o,     1'b0);
      check("post_rst_ready", fe_queue_ready_o, 1'b1);
      check("post_rst_count", count_o,          3'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
